// File: rtl/datapath2_pipe_if.sv
// Instruction/result bus of datapath2_pipe.
//   slave  : the datapath (takes instructions, presents results, serves debug reads)
//   master : instruction source / result consumer
// Instruction side: i_valid/o_ready, i_ALUSrc, i_AddSub, i_WE, i_RA0, i_RA1, i_WA, i_Im
// Result side     : o_valid/i_ready, o_ALUout, o_Cout, o_Overflow, o_Zero, o_WA
// Debug           : i_dbg_addr -> o_dbg_data (combinational)
interface datapath2_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned IMM_W = 16
);
   localparam int unsigned AW = $clog2(NREGS);

   logic             i_valid;
   logic             o_ready;
   logic             i_ALUSrc;
   logic             i_AddSub;
   logic             i_WE;
   logic [AW-1:0]    i_RA0;
   logic [AW-1:0]    i_RA1;
   logic [AW-1:0]    i_WA;
   logic [IMM_W-1:0] i_Im;

   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_ALUout;
   logic             o_Cout;
   logic             o_Overflow;
   logic             o_Zero;
   logic [AW-1:0]    o_WA;

   logic [AW-1:0]    i_dbg_addr;
   logic [WIDTH-1:0] o_dbg_data;

   modport slave (
      input  i_valid, i_ALUSrc, i_AddSub, i_WE, i_RA0, i_RA1, i_WA, i_Im,
      input  i_ready, i_dbg_addr,
      output o_ready, o_valid, o_ALUout, o_Cout, o_Overflow, o_Zero, o_WA, o_dbg_data
   );

   modport master (
      output i_valid, i_ALUSrc, i_AddSub, i_WE, i_RA0, i_RA1, i_WA, i_Im,
      output i_ready, i_dbg_addr,
      input  o_ready, o_valid, o_ALUout, o_Cout, o_Overflow, o_Zero, o_WA, o_dbg_data
   );
endinterface

// File: rtl/datapath2_pipe.sv
// Two-stage pipelined add/sub datapath over an NREGS x WIDTH register file.
// S1 holds read operands, S2 holds the result and flags presented on the output.
// The register file is written as an instruction moves S1 -> S2.
// Ports:
//   i_CLK   : clock, all state on rising edge
//   i_RST_N : asynchronous active-low reset
//   bus     : datapath2_pipe_if.slave (instruction, result and debug signals)
// Optional feature: define DP_FORWARD_EN to bypass the S1 result to dependent
// operands instead of stalling one cycle per dependency.
module datapath2_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned IMM_W = 16
) (
   input  logic            i_CLK,
   input  logic            i_RST_N,
   datapath2_pipe_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);

   logic [WIDTH-1:0] regs_q [NREGS];

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_sub_q, s1_sub_d;
   logic             s1_we_q, s1_we_d;
   logic [AW-1:0]    s1_wa_q, s1_wa_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_res_q, s2_res_d;
   logic             s2_cout_q, s2_cout_d;
   logic             s2_ovf_q, s2_ovf_d;
   logic             s2_zero_q, s2_zero_d;
   logic [AW-1:0]    s2_wa_q, s2_wa_d;

   logic             s2_load_c, s1_adv_c, accept_c, hazard_c, wr_en_c;
   logic             s1_pending_c, hit0_c, hit1_c;
   logic [WIDTH-1:0] imm_c, rd0_c, rd1_c, opa_c, opb_c;
   logic [WIDTH-1:0] b_eff_c, alu_res_c;
   logic             alu_cout_c, alu_ovf_c;

   // ALU: subtract as A + ~B + 1; overflow when equal-sign inputs give a different-sign sum
   assign b_eff_c = s1_sub_q ? ~s1_b_q : s1_b_q;
   assign {alu_cout_c, alu_res_c} = {1'b0, s1_a_q} + {1'b0, b_eff_c} + (WIDTH+1)'(s1_sub_q);
   assign alu_ovf_c = (s1_a_q[WIDTH-1] == b_eff_c[WIDTH-1]) && (alu_res_c[WIDTH-1] != s1_a_q[WIDTH-1]);

   // Handshake
   assign s2_load_c = !s2_valid_q || bus.i_ready;
   assign s1_adv_c  = s1_valid_q && s2_load_c;
   assign accept_c  = bus.i_valid && bus.o_ready;
   assign bus.o_ready = (!s1_valid_q || s1_adv_c) && !hazard_c;

   // Operand read; S1 result is not yet in the register file when a dependent is accepted
   assign s1_pending_c = s1_valid_q && s1_we_q && (s1_wa_q != '0);
   assign hit0_c = s1_pending_c && (bus.i_RA0 == s1_wa_q);
   assign hit1_c = s1_pending_c && (bus.i_RA1 == s1_wa_q);
   assign imm_c  = WIDTH'($signed(bus.i_Im));
   assign rd0_c  = regs_q[bus.i_RA0];
   assign rd1_c  = regs_q[bus.i_RA1];

`ifdef DP_FORWARD_EN
   assign hazard_c = 1'b0;
   assign opa_c    = hit0_c ? alu_res_c : rd0_c;
   assign opb_c    = bus.i_ALUSrc ? imm_c : (hit1_c ? alu_res_c : rd1_c);
`else
   assign hazard_c = hit0_c || (hit1_c && !bus.i_ALUSrc);
   assign opa_c    = rd0_c;
   assign opb_c    = bus.i_ALUSrc ? imm_c : rd1_c;
`endif

   // Pipeline next state
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_sub_d   = s1_sub_q;
      s1_we_d    = s1_we_q;
      s1_wa_d    = s1_wa_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_cout_d  = s2_cout_q;
      s2_ovf_d   = s2_ovf_q;
      s2_zero_d  = s2_zero_q;
      s2_wa_d    = s2_wa_q;
      wr_en_c    = 1'b0;
      if (s1_adv_c) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b1;
         s2_res_d   = alu_res_c;
         s2_cout_d  = alu_cout_c;
         s2_ovf_d   = alu_ovf_c;
         s2_zero_d  = (alu_res_c == '0);
         s2_wa_d    = s1_wa_q;
         wr_en_c    = s1_we_q && (s1_wa_q != '0);
      end else if (bus.i_ready) begin
         s2_valid_d = 1'b0;
      end
      if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_a_d     = opa_c;
         s1_b_d     = opb_c;
         s1_sub_d   = bus.i_AddSub;
         s1_we_d    = bus.i_WE;
         s1_wa_d    = bus.i_WA;
      end
   end

   // Pipeline registers
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sub_q   <= 1'b0;
         s1_we_q    <= 1'b0;
         s1_wa_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_cout_q  <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_wa_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_sub_q   <= s1_sub_d;
         s1_we_q    <= s1_we_d;
         s1_wa_q    <= s1_wa_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_cout_q  <= s2_cout_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_zero_q  <= s2_zero_d;
         s2_wa_q    <= s2_wa_d;
      end
   end

   // Register file; R0 is never written so it always reads 0
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en_c) begin
         regs_q[s1_wa_q] <= alu_res_c;
      end
   end

   assign bus.o_valid    = s2_valid_q;
   assign bus.o_ALUout   = s2_res_q;
   assign bus.o_Cout     = s2_cout_q;
   assign bus.o_Overflow = s2_ovf_q;
   assign bus.o_Zero     = s2_zero_q;
   assign bus.o_WA       = s2_wa_q;
   assign bus.o_dbg_data = regs_q[bus.i_dbg_addr];
endmodule

// File: tb/tb_datapath2_pipe.sv
// Self-checking bench for datapath2_pipe (WIDTH=32, NREGS=32, IMM_W=16).
// Expected results come from a sequential reference model and are queued on accept.
module tb_datapath2_pipe;
   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic [4:0]  wa;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   datapath2_pipe_if #(.WIDTH(32), .NREGS(32), .IMM_W(16)) dp_bus ();

   datapath2_pipe #(.WIDTH(32), .NREGS(32), .IMM_W(16)) u_dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .bus     (dp_bus)
   );

   exp_t        sb_q[$];
   exp_t        got_q[$];
   logic [31:0] mreg [32];
   int          n_pass = 0;
   int          n_total = 0;
   bit          hold_prev = 1'b0;
   exp_t        held;

   // Reference model: execute the presented instruction in program order
   task automatic model_push();
      logic [31:0] a, b, r;
      logic [63:0] t;
      logic        c, v;
      longint      sa, sbv, st, lim;
      exp_t        e;
      a   = mreg[dp_bus.i_RA0];
      b   = dp_bus.i_ALUSrc ? 32'($signed(dp_bus.i_Im)) : mreg[dp_bus.i_RA1];
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      lim = longint'(1) << 31;
      if (!dp_bus.i_AddSub) begin
         t  = {32'b0, a} + {32'b0, b};
         r  = t[31:0];
         c  = t[32];
         st = sa + sbv;
      end else begin
         r  = a - b;
         c  = (a >= b);
         st = sa - sbv;
      end
      v = (st >= lim) || (st < -lim);
      e = '{res: r, c: c, v: v, z: (r == 32'd0), wa: dp_bus.i_WA};
      sb_q.push_back(e);
      if (dp_bus.i_WE && dp_bus.i_WA != 5'd0) mreg[dp_bus.i_WA] = r;
   endtask

   // One clock: sample, score output handshake, model input accept, advance to next negedge
   task automatic cycle(output bit acc);
      exp_t act, e;
      #1;
      act = '{res: dp_bus.o_ALUout, c: dp_bus.o_Cout, v: dp_bus.o_Overflow,
              z: dp_bus.o_Zero, wa: dp_bus.o_WA};
      if (hold_prev) begin
         n_total++;
         if (dp_bus.o_valid !== 1'b1 || act !== held)
            $display("FAIL hold_stable: got valid=%b out=%h want valid=1 out=%h", dp_bus.o_valid, act, held);
         else n_pass++;
      end
      hold_prev = dp_bus.o_valid && !dp_bus.i_ready;
      held = act;
      if (dp_bus.o_valid && dp_bus.i_ready) begin
         n_total++;
         if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_extra: got out=%h want no result", act);
         end else begin
            e = sb_q.pop_front();
            if (act !== e) $display("FAIL scoreboard: got %h want %h", act, e);
            else n_pass++;
         end
         got_q.push_back(act);
      end
      acc = dp_bus.i_valid && dp_bus.o_ready;
      if (acc) model_push();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one instruction until accepted; returns number of stalled cycles
   task automatic issue(input bit alusrc, input bit sub, input bit we, input logic [4:0] ra0,
                        input logic [4:0] ra1, input logic [4:0] wa, input logic [15:0] im,
                        output int stalls);
      bit acc;
      stalls = 0;
      dp_bus.i_ALUSrc = alusrc;
      dp_bus.i_AddSub = sub;
      dp_bus.i_WE     = we;
      dp_bus.i_RA0    = ra0;
      dp_bus.i_RA1    = ra1;
      dp_bus.i_WA     = wa;
      dp_bus.i_Im     = im;
      dp_bus.i_valid  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cycle(acc);
         if (acc) break;
         stalls++;
      end
      dp_bus.i_valid = 1'b0;
      if (stalls >= 20) begin
         n_total++;
         $display("FAIL issue_timeout: got no accept in %0d cycles want accept", stalls);
      end
   endtask

   task automatic drain();
      bit acc;
      int k;
      dp_bus.i_valid = 1'b0;
      dp_bus.i_ready = 1'b1;
      for (k = 0; k < 50 && sb_q.size() > 0; k++) cycle(acc);
      cycle(acc);
      if (sb_q.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
      end
   endtask

   task automatic test_reset();
      int st;
      dp_bus.i_ready = 1'b0;
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd20, 16'h0055, st);
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd21, 16'h0066, st);
      #1;
      n_total++;
      if (dp_bus.o_ready !== 1'b0) $display("FAIL full_backpressure_ready: got %b want 0", dp_bus.o_ready);
      else n_pass++;
      dp_bus.i_dbg_addr = 5'd20;
      #1;
      n_total++;
      if (dp_bus.o_dbg_data !== 32'h55) $display("FAIL pre_reset_r20: got %h want 00000055", dp_bus.o_dbg_data);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (dp_bus.o_valid !== 1'b0 || dp_bus.o_ALUout !== 32'd0 || dp_bus.o_WA !== 5'd0 ||
          dp_bus.o_Cout !== 1'b0 || dp_bus.o_Overflow !== 1'b0 || dp_bus.o_Zero !== 1'b0)
         $display("FAIL reset_outputs: got valid=%b out=%h wa=%0d c=%b v=%b z=%b want all 0",
                  dp_bus.o_valid, dp_bus.o_ALUout, dp_bus.o_WA, dp_bus.o_Cout, dp_bus.o_Overflow, dp_bus.o_Zero);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
         dp_bus.i_dbg_addr = 5'(i);
         #1;
         n_total++;
         if (dp_bus.o_dbg_data !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", i, dp_bus.o_dbg_data);
         else n_pass++;
      end
      sb_q.delete();
      got_q.delete();
      hold_prev = 1'b0;
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      dp_bus.i_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_total++;
      if (dp_bus.o_ready !== 1'b1 || dp_bus.o_valid !== 1'b0)
         $display("FAIL post_reset: got ready=%b valid=%b want ready=1 valid=0", dp_bus.o_ready, dp_bus.o_valid);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_imm();
      int st;
      got_q.delete();
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 16'h8000, st);
      issue(1'b0, 1'b1, 1'b1, 5'd1, 5'd1, 5'd2, 16'h0000, st);
      drain();
      n_total++;
      if (got_q.size() != 2) $display("FAIL imm_count: got %0d want 2", got_q.size());
      else begin
         n_pass++;
         n_total++;
         if (got_q[0].res !== 32'hFFFF8000 || got_q[0].v !== 1'b0)
            $display("FAIL imm_sext: got %h v=%b want ffff8000 v=0", got_q[0].res, got_q[0].v);
         else n_pass++;
         n_total++;
         if (got_q[1].res !== 32'd0 || got_q[1].z !== 1'b1 || got_q[1].c !== 1'b1)
            $display("FAIL sub_self: got %h z=%b c=%b want 0 z=1 c=1", got_q[1].res, got_q[1].z, got_q[1].c);
         else n_pass++;
      end
   endtask

   task automatic test_flags();
      int st;
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 16'h4000, st);
      for (int i = 0; i < 17; i++) issue(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 16'h0, st);
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 16'hFFFF, st);
      issue(1'b0, 1'b1, 1'b1, 5'd4, 5'd5, 5'd3, 16'h0, st);
      drain();
      got_q.delete();
      issue(1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 16'h0001, st);
      issue(1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 5'd4, 16'h0001, st);
      drain();
      n_total++;
      if (got_q.size() != 2) $display("FAIL flags_count: got %0d want 2", got_q.size());
      else begin
         n_pass++;
         n_total++;
         if (got_q[0].res !== 32'h80000000 || got_q[0].v !== 1'b1 || got_q[0].c !== 1'b0)
            $display("FAIL add_overflow: got %h v=%b c=%b want 80000000 v=1 c=0", got_q[0].res, got_q[0].v, got_q[0].c);
         else n_pass++;
         n_total++;
         if (got_q[1].res !== 32'd0 || got_q[1].c !== 1'b1 || got_q[1].z !== 1'b1)
            $display("FAIL add_carry: got %h c=%b z=%b want 0 c=1 z=1", got_q[1].res, got_q[1].c, got_q[1].z);
         else n_pass++;
      end
   endtask

   task automatic test_chain();
      int st, total;
`ifdef DP_FORWARD_EN
      int exp_stalls = 0;
`else
      int exp_stalls = 2;
`endif
      got_q.delete();
      dp_bus.i_ready = 1'b1;
      total = 0;
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 16'd5, st);
      total += st;
      issue(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd1, 16'd5, st);
      total += st;
      issue(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd1, 16'd5, st);
      total += st;
      drain();
      n_total++;
      if (total != exp_stalls) $display("FAIL chain_stalls: got %0d want %0d", total, exp_stalls);
      else n_pass++;
      n_total++;
      if (got_q.size() != 3 || got_q[0].res !== 32'd5 || got_q[1].res !== 32'd10 || got_q[2].res !== 32'd15)
         $display("FAIL chain_values: got n=%0d want 5,10,15", got_q.size());
      else n_pass++;
   endtask

   task automatic test_dbg_prewrite();
      int st;
      dp_bus.i_ready = 1'b1;
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 16'd9, st);
      dp_bus.i_dbg_addr = 5'd6;
      #1;
      n_total++;
      if (dp_bus.o_dbg_data !== 32'd0) $display("FAIL dbg_prewrite: got %h want 0", dp_bus.o_dbg_data);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_total++;
      if (dp_bus.o_dbg_data !== 32'd9) $display("FAIL dbg_postwrite: got %h want 9", dp_bus.o_dbg_data);
      else n_pass++;
      drain();
   endtask

   task automatic test_backpressure();
      bit acc;
      int idx = 0;
      int c = 0;
      got_q.delete();
      while ((idx < 8 || sb_q.size() > 0) && c < 200) begin
         dp_bus.i_ready = ((c % 4) == 0) || ((c % 4) == 3);
         if (idx < 8) begin
            dp_bus.i_valid  = 1'b1;
            dp_bus.i_ALUSrc = 1'b1;
            dp_bus.i_AddSub = 1'b0;
            dp_bus.i_WE     = 1'b1;
            dp_bus.i_RA0    = 5'd0;
            dp_bus.i_RA1    = 5'd0;
            dp_bus.i_WA     = 5'(10 + idx);
            dp_bus.i_Im     = 16'(idx * 3 + 1);
         end else begin
            dp_bus.i_valid = 1'b0;
         end
         cycle(acc);
         if (acc) idx++;
         c++;
      end
      dp_bus.i_valid = 1'b0;
      dp_bus.i_ready = 1'b1;
      n_total++;
      if (got_q.size() != 8 || c >= 200) $display("FAIL bp_count: got %0d results want 8", got_q.size());
      else n_pass++;
      for (int k = 0; k < got_q.size() && k < 8; k++) begin
         n_total++;
         if (got_q[k].wa !== 5'(10 + k) || got_q[k].res !== 32'(k * 3 + 1))
            $display("FAIL bp_order%0d: got wa=%0d res=%h want wa=%0d res=%h", k, got_q[k].wa, got_q[k].res, 10 + k, k * 3 + 1);
         else n_pass++;
      end
   endtask

   task automatic test_r0_write();
      int st;
      got_q.delete();
      issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 16'd7, st);
      drain();
      n_total++;
      if (got_q.size() != 1 || got_q[0].res !== 32'd7 || got_q[0].wa !== 5'd0)
         $display("FAIL r0_result: got n=%0d want one result 7 at wa 0", got_q.size());
      else n_pass++;
      dp_bus.i_dbg_addr = 5'd0;
      #1;
      n_total++;
      if (dp_bus.o_dbg_data !== 32'd0) $display("FAIL r0_stays_zero: got %h want 0", dp_bus.o_dbg_data);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      rst_n             = 1'b0;
      dp_bus.i_valid    = 1'b0;
      dp_bus.i_ALUSrc   = 1'b0;
      dp_bus.i_AddSub   = 1'b0;
      dp_bus.i_WE       = 1'b0;
      dp_bus.i_RA0      = 5'd0;
      dp_bus.i_RA1      = 5'd0;
      dp_bus.i_WA       = 5'd0;
      dp_bus.i_Im       = 16'd0;
      dp_bus.i_ready    = 1'b1;
      dp_bus.i_dbg_addr = 5'd0;
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_imm();
      test_flags();
      test_chain();
      test_dbg_prewrite();
      test_backpressure();
      test_r0_write();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/datapath2_pipe.md
# datapath2_pipe

Parametrised, pipelined successor to the single-cycle adder/register-file datapath. Accepts one ALU instruction per cycle over a valid/ready handshake, reads a NREGS×WIDTH register file, performs add/sub on register or sign-extended immediate operands, and writes back while presenting result and flags on a backpressured output port. Sits between the logic-analyzer/Wishbone-driven instruction source and the IO/LA result capture in the user project.

## Interface
- WIDTH, 32, datapath and register width (≥8)
- NREGS, 32, register count (power of two, ≥4); AW = $clog2(NREGS)
- IMM_W, 16, immediate width (≤ WIDTH)
- i_CLK  in  1  single clock; all state on rising edge
- i_RST_N  in  1  asynchronous, active-low reset
- i_valid  in  1  instruction presented
- o_ready  out  1  instruction accepted when i_valid && o_ready
- i_ALUSrc  in  1  0: B = R[RA1]; 1: B = sext(Im)
- i_AddSub  in  1  0: A+B; 1: A−B
- i_WE  in  1  write result to R[WA]
- i_RA0, i_RA1, i_WA  in  AW each  source/dest register indices
- i_Im  in  IMM_W  immediate
- o_valid  out  1  result presented
- i_ready  in  1  consumer accepts result when o_valid && i_ready
- o_ALUout  out  WIDTH  result
- o_Cout, o_Overflow, o_Zero  out  1 each  flags of o_ALUout
- o_WA  out  AW  destination index of presented result
- i_dbg_addr  in  AW  debug read index
- o_dbg_data  out  WIDTH  R[i_dbg_addr], combinational

## Operation
- R0 reads as 0; writes to R0 discarded.
- Two pipeline registers: S1 (operands A, B, AddSub, WE, WA) and S2 (result, flags, WA).
- Accept: operands read from register file (plus forwarding, see Configuration) and loaded into S1; S1 valid set.
- S2_load = !S2_valid || i_ready. S1 advances when S1_valid && S2_load: ALU output loaded into S2, S2_valid set; if WE && WA≠0, R[WA] written on the same edge.
- S2 cleared when result handed off and S1 not advancing.
- o_ready = (!S1_valid || S1_advance) && !hazard_stall.
- ALU: sub computes A + ~B + 1. Cout = carry out of bit WIDTH−1 (sub: 1 = no borrow). Overflow = signed overflow of the WIDTH-bit operation. Zero = (result == 0). Immediate sign-extended from bit IMM_W−1.
- No instruction is dropped or duplicated under any backpressure pattern.

## Timing
- Reset: o_ready=1 (combinational from cleared state), o_valid=0, o_ALUout=0, all flags 0, o_WA=0, all registers R[i]=0, S1/S2 invalid.
- Latency: instruction accepted at edge N → o_valid high after edge N+1 if i_ready held; register write at edge N+1.
- Throughput: 1 instruction/cycle with i_ready=1 and forwarding enabled.
- i_ready low with S2 and S1 full → o_ready low; outputs stable until handshake.
- Reset mid-operation: in-flight instructions discarded, register file cleared, no partial write.
- Debug read returns pre-write value on the cycle a write to the same index occurs.

## Configuration
- DP_FORWARD_EN defined: hazard_stall=0; a source index equal to S1.WA (S1 valid, WE, WA≠0) takes the S1 ALU output instead of the register file (back-to-back dependents at full rate).
- Undefined: no bypass; hazard_stall=1 when S1 valid, WE, WA≠0 and WA matches RA0, or RA1 with ALUSrc=0; costs one bubble per dependency.

## Test plan
- Reset: assert i_RST_N=0 mid-stream → o_valid=0, o_ALUout=0, o_dbg_data=0 for every index, o_ready=1 after release.
- Immediate/sign-extend: R1←R0+Im 0x8000 (IMM_W=16) → o_ALUout=0xFFFF8000, Overflow=0; R2←R1−R1 → 0, Zero=1, Cout=1.
- Flags: R3=0x7FFFFFFF, add Im 1 → 0x80000000, Overflow=1, Cout=0; R4=0xFFFFFFFF add Im 1 → 0, Cout=1, Zero=1.
- Dependency chain: R1←R0+5, R1←R1+5, R1←R1+5 back-to-back → results 5, 10, 15; with DP_FORWARD_EN in 3 consecutive accepts, without it one o_ready=0 cycle between each.
- Backpressure: 8 independent instructions, i_ready toggling 1,0,0,1,… → exactly 8 results in order, values unchanged while o_valid && !i_ready.
- R0 write: WE=1, WA=0, Im 7 → o_ALUout=7, o_WA=0, o_dbg_data for index 0 remains 0.
